// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target register block and its bus front end.
//   i2c_state_e  : target FSM state encoding (4 bits, IDLE..WAIT)
//   ACK / NACK   : SDA level of the acknowledge slot
//   RW_WRITE/READ: value of the R/W bit in the address byte
//   addr_match() : compares the 7-bit address field of an address byte
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ADDR  = 4'd1,
        ACK_A = 4'd2,
        REG   = 4'd3,
        ACK_R = 4'd4,
        WR    = 4'd5,
        ACK_W = 4'd6,
        RD    = 4'd7,
        MACK  = 4'd8,
        WAIT  = 4'd9
    } i2c_state_e;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_slave_regs_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_regs_if
// Bus and write-notification signals of the I2C target register block.
//   scl_in, sda_in : bus line levels seen by the target (sda is wired-AND)
//   sda_oe         : 1 = target pulls SDA low
//   wr_stb/wr_addr/wr_data : one-cycle notification of a committed byte
//   busy           : target is addressed and engaged in a transfer
// Modports: slave (the target), master (bus side / environment).
// ---------------------------------------------------------------------------
interface i2c_slave_regs_if;

    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, wr_stb, wr_addr, wr_data, busy
    );

    modport master (
        output scl_in, sda_in,
        input  sda_oe, wr_stb, wr_addr, wr_data, busy
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings SCL/SDA into the clk domain and derives bus events.
//   clk, rst      : clock, synchronous active-low reset
//   scl_in,sda_in : raw bus levels
//   scl_rise/fall : one-cycle SCL edge strobes
//   start_det     : SDA falling while SCL high
//   stop_det      : SDA rising while SCL high
//   sda_s         : conditioned SDA level
// Build option I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority/hold filter
// per line after the synchronizer (2 clk extra latency).
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_p0;
    logic [SYNC_STAGES-1:0] sda_p0;
    logic                   scl_raw;
    logic                   sda_raw;
    logic                   scl_lvl;
    logic                   sda_lvl;
    logic                   scl_p1;
    logic                   sda_p1;

    // Stage 0: synchronizer chains, idle-high after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_p0 <= '1;
            sda_p0 <= '1;
        end else begin
            scl_p0 <= {scl_p0[SYNC_STAGES-2:0], scl_in};
            sda_p0 <= {sda_p0[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign scl_raw = scl_p0[SYNC_STAGES-1];
    assign sda_raw = sda_p0[SYNC_STAGES-1];

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_hold;
    logic       sda_hold;

    // Level only moves once the current sample and the two before it agree
    assign scl_lvl = (scl_raw == scl_hist[0] && scl_hist[0] == scl_hist[1]) ? scl_raw : scl_hold;
    assign sda_lvl = (sda_raw == sda_hist[0] && sda_hist[0] == sda_hist[1]) ? sda_raw : sda_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_hold <= 1'b1;
            sda_hold <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_raw};
            sda_hist <= {sda_hist[0], sda_raw};
            scl_hold <= scl_lvl;
            sda_hold <= sda_lvl;
        end
    end
`else
    assign scl_lvl = scl_raw;
    assign sda_lvl = sda_raw;
`endif

    // Stage 1: previous conditioned level for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_p1 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p1 <= scl_lvl;
            sda_p1 <= sda_lvl;
        end
    end

    assign scl_rise  = scl_lvl & ~scl_p1;
    assign scl_fall  = ~scl_lvl & scl_p1;
    // SCL must be high on both samples so an SCL edge never fakes START/STOP
    assign start_det = scl_lvl & scl_p1 & sda_p1 & ~sda_lvl;
    assign stop_det  = scl_lvl & scl_p1 & ~sda_p1 & sda_lvl;
    assign sda_s     = sda_lvl;

endmodule

// File: rtl/i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// i2c_slave_regs
// I2C target with an internal register file. After address match a write
// transfer takes a pointer byte followed by data bytes; a read transfer
// returns bytes from the current pointer. The pointer auto-increments and
// wraps at NUM_REGS in both directions.
//   clk, rst : clock, synchronous active-low reset
//   bus      : i2c_slave_regs_if.slave (scl_in, sda_in, sda_oe, wr_stb,
//              wr_addr, wr_data, busy)
//   dbg_regs : flattened register file, reg0 in [7:0]
// Build option I2C_SLV_GLITCH_FILTER_EN enables the line glitch filter
// inside i2c_bus_sync.
// ---------------------------------------------------------------------------
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_slave_regs_if.slave       bus,
    output logic [8*NUM_REGS-1:0] dbg_regs
);

    localparam int PTR_W = $clog2(NUM_REGS);

    logic             scl_rise;
    logic             scl_fall;
    logic             start_det;
    logic             stop_det;
    logic             sda_s;

    i2c_state_e       state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       regs [NUM_REGS];
    logic             sda_oe_r;
    logic             wr_stb_r;
    logic [7:0]       wr_addr_r;
    logic [7:0]       wr_data_r;
    logic             busy_r;
    logic [7:0]       rx_byte;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    // Byte as it stands once the bit on the current SCL rise is included
    assign rx_byte = {shift[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            sda_oe_r  <= 1'b0;
            wr_stb_r  <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            busy_r    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_stb_r <= 1'b0;
            if (stop_det) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
            end else if (start_det) begin
                // Repeated START keeps the pointer so a register select can
                // be followed by a restart-read
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state)
                    IDLE, WAIT: begin
                        sda_oe_r <= 1'b0;
                    end
                    ADDR, REG, WR: begin
                        if (scl_fall) begin
                            sda_oe_r <= 1'b0;
                        end
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    if (addr_match(rx_byte, DEV_ADDR)) begin
                                        state  <= ACK_A;
                                        busy_r <= 1'b1;
                                    end else begin
                                        state  <= WAIT;
                                    end
                                end else if (state == REG) begin
                                    ptr   <= rx_byte[PTR_W-1:0];
                                    state <= ACK_R;
                                end else begin
                                    state <= ACK_W;
                                end
                            end
                        end
                    end
                    ACK_A, ACK_R, ACK_W: begin
                        // Falling edge after the 8th bit: drive ACK, and for a
                        // data byte commit it on this same edge
                        if (scl_fall) begin
                            sda_oe_r <= ~ACK;
                            if (state == ACK_W) begin
                                regs[ptr] <= shift;
                                wr_stb_r  <= 1'b1;
                                wr_addr_r <= 8'(ptr);
                                wr_data_r <= shift;
                                ptr       <= ptr + 1'b1;
                            end
                        end
                        // 9th rising edge ends the ACK slot; ACK stays driven
                        // until the next falling edge
                        if (scl_rise) begin
                            if (state == ACK_A) begin
                                if (shift[0] == RW_READ) begin
                                    state <= RD;
                                    shift <= regs[ptr];
                                end else begin
                                    state <= REG;
                                end
                            end else begin
                                state <= WR;
                            end
                        end
                    end
                    RD: begin
                        // Drive zeros, release for ones
                        if (scl_fall) begin
                            sda_oe_r <= ~shift[7];
                            shift    <= {shift[6:0], 1'b0};
                        end
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= MACK;
                                ptr   <= ptr + 1'b1;
                            end
                        end
                    end
                    MACK: begin
                        if (scl_fall) begin
                            sda_oe_r <= 1'b0;
                        end
                        if (scl_rise) begin
                            if (sda_s == ACK) begin
                                state <= RD;
                                shift <= regs[ptr];
                            end else begin
                                state  <= WAIT;
                                busy_r <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe  = sda_oe_r;
    assign bus.wr_stb  = wr_stb_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;
    assign bus.busy    = busy_r;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dbg
        assign dbg_regs[8*gi +: 8] = regs[gi];
    end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target device consuming the SCL/SDA stream produced by the team's I2C master.
- Same-clock bus model, 8 clk per SCL period.
- Decodes START/STOP/repeated-START, matches a 7-bit device address, then takes a register pointer byte.
- Services write data into an internal register file, or serves read data from it; drives ACK and read bits onto SDA.

Parameters:
DEV_ADDR, 7'h50, 7-bit address this target answers to
NUM_REGS, 16, register file depth (power of 2, 2..256)
SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
scl_in  in  1  bus SCL level
sda_in  in  1  bus SDA level (wired-AND of all drivers)
sda_oe  out  1  1 = pull SDA low; 0 = release
wr_stb  out  1  one-cycle pulse when a data byte is committed
wr_addr  out  8  register index of the committed byte
wr_data  out  8  committed byte
busy  out  1  high from address match until STOP/START/NACK exit
dbg_regs  out  8*NUM_REGS  flattened register file, reg0 in [7:0]

Behaviour:
- Reset (rst=0 at posedge): state IDLE, sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, all registers 0, pointer 0, synchronizers loaded with 1.
- scl_in/sda_in pass SYNC_STAGES flops; edges from last stage vs. its previous value.
- START: sda falls while scl high. STOP: sda rises while scl high. Both are checked every cycle and override any state.
- Bits sampled on SCL rising edge. sda_oe updates on SCL falling edge, plus the cycle after.
- Bit counter 0..7, MSB first; 9th clock is ACK slot.
- States:
  - IDLE: wait START -> ADDR.
  - ADDR: shift 8 bits.
    - Addr[7:1]==DEV_ADDR -> ACK_A, busy=1.
    - Else -> WAIT (sda_oe stays 0, NACK by release).
  - ACK_A: drive 0 for the 9th SCL.
    - R/W=0 -> REG.
    - R/W=1 -> RD (current pointer).
  - REG: shift 8 bits -> ACK_R; pointer = byte mod NUM_REGS.
  - ACK_R: drive ACK -> WR.
  - WR: shift 8 bits -> ACK_W.
    - Register file written at ACK drive edge.
    - wr_stb pulses same cycle; wr_addr=pointer, wr_data=byte.
    - Pointer increments mod NUM_REGS; -> WR.
  - RD: drive bit of regs[pointer], load on entry, release SDA for 1s.
    - After 8th bit -> MACK; pointer increments mod NUM_REGS.
  - MACK: release SDA, sample master bit on SCL rise.
    - 0 -> RD with next byte.
    - 1 -> WAIT.
  - WAIT: sda_oe=0, busy=0; exit only via START/STOP.
- Repeated START in any state: ADDR, counter cleared, sda_oe=0 next cycle, pointer kept (register-select then restart-read works).
- STOP in any state: IDLE, sda_oe=0, busy=0, a partial byte discarded (no wr_stb).
- Pointer wraps NUM_REGS-1 -> 0 for both write and read bursts.
- sda_oe never asserted while scl high except held ACK/read bit from preceding falling edge.
- Reset mid-transfer: immediate return to reset values; bus resumes on next START.

Optional Feature:
- Macro I2C_SLV_GLITCH_FILTER_EN.
- Defined: after synchronizers, each line passes a 3-sample majority/hold filter; level changes only after 3 consecutive equal samples. Adds 2 clk detection latency.
- Undefined: raw synchronized levels used directly, no added latency.

Decomposition:
- Shared package i2c_pkg:
  - state enum encodings (IDLE..WAIT, 4-bit)
  - ACK=1'b0, NACK=1'b1
  - RW_WRITE=0, RW_READ=1
- Sub-module i2c_bus_sync:
  - synchronizer, optional filter, edge detect.
  - Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
  - Reused later by master-side bus monitor.

Test Plan:
- Write: START, 0xA0, 0x03, 0x5A, STOP -> three ACKs (sda_oe=1 in each 9th SCL); wr_stb once with wr_addr=3, wr_data=0x5A; dbg_regs reg3=0x5A.
- Burst write wrap: ptr 0x0F, data 0x11,0x22 -> reg15=0x11, reg0=0x22, two wr_stb pulses.
- Random read: START,0xA0,0x03,repeated START,0xA1, master ACK then NACK -> bytes 0x5A then reg4 (0x00) on SDA; WAIT after NACK.
- Address mismatch: START, 0xA2 -> sda_oe stays 0 through ACK slot; busy=0; no wr_stb until STOP.
- Abort: STOP after 4 data bits -> no wr_stb, state IDLE, regs unchanged.
- rst=0 mid-read byte -> next cycle sda_oe=0, busy=0, all regs 0.
